// File: rtl/pfpu32_i2f_conv_pkg.sv
// rtl/pfpu32_i2f_conv_pkg.sv - shared FPU constants: rounding modes and exponent biases
package pfpu32_i2f_conv_pkg;

    // Rounding-mode encodings carried on rmode_i
    localparam logic [1:0] RM_RNE = 2'b00;  // round to nearest, ties to even
    localparam logic [1:0] RM_RTZ = 2'b01;  // round toward zero
    localparam logic [1:0] RM_RUP = 2'b10;  // round toward +inf
    localparam logic [1:0] RM_RDN = 2'b11;  // round toward -inf

    // Single-precision exponent bias
    localparam logic [7:0] EXP_BIAS = 8'd127;

    // Biased exponent of a 32-bit magnitude with bit31 set: 127 + 31
    localparam logic [7:0] EXP_I2F_TOP = 8'd158;

endpackage

// File: rtl/pfpu32_clz32.sv
// rtl/pfpu32_clz32.sv - 32-bit leading-zero counter with all-zero flag
module pfpu32_clz32 (
    input  logic [31:0] value,
    output logic [4:0]  count,
    output logic        zero
);

    // Scan from the MSB; the first set bit fixes the count. An all-zero
    // input leaves the count at 0 and is reported through the zero flag.
    always_comb begin
        logic found;
        count = 5'd0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found && value[i]) begin
                count = 5'(31 - i);
                found = 1'b1;
            end
        end
        zero = ~|value;
    end

endmodule

// File: rtl/pfpu32_i2f_conv.sv
// rtl/pfpu32_i2f_conv.sv - three-stage int32 to single-precision float converter
module pfpu32_i2f_conv
    import pfpu32_i2f_conv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        adv_i,
    input  logic        start_i,
    input  logic [31:0] opa_i,
    input  logic [1:0]  rmode_i,
    output logic        i2f_rdy_o,
    output logic [31:0] i2f_result_o,
    output logic        i2f_inexact_o,
    output logic        i2f_zero_o
);

    // Stage 1: sign / magnitude
    logic        s1_valid;
    logic        s1_sign;
    logic [31:0] s1_mag;
    logic [1:0]  s1_rmode;

    // Stage 2: normalized mantissa
    logic        s2_valid;
    logic        s2_sign;
    logic [31:0] s2_shifted;
    logic [7:0]  s2_exp;
    logic        s2_zero;
    logic [1:0]  s2_rmode;

    // Stage 3: rounded result
    logic        s3_valid;
    logic [31:0] s3_result;
    logic        s3_inexact;
    logic        s3_zero;

    logic [4:0]  lz;
    logic        mag_zero;

    // Rounding datapath on stage-2 contents
    logic [22:0] frac;
    logic [22:0] frac_rnd;
    logic        rnd_carry;
    logic        lsb;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [7:0]  exp_rnd;
    logic [31:0] result_rnd;

    // Absolute value; the most negative input maps onto itself as an unsigned 2^31
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= 32'd0;
            s1_rmode <= 2'b00;
        end else begin
            if (flush_i) begin
                s1_valid <= 1'b0;
            end else if (adv_i) begin
                s1_valid <= start_i;
            end
            if (adv_i && start_i) begin
                s1_sign  <= opa_i[31];
                s1_mag   <= opa_i[31] ? (~opa_i + 32'd1) : opa_i;
                s1_rmode <= rmode_i;
            end
        end
    end

    pfpu32_clz32 u_clz (
        .value (s1_mag),
        .count (lz),
        .zero  (mag_zero)
    );

    // Normalize so the leading one lands in bit31 and derive the biased exponent
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_sign    <= 1'b0;
            s2_shifted <= 32'd0;
            s2_exp     <= 8'd0;
            s2_zero    <= 1'b0;
            s2_rmode   <= 2'b00;
        end else begin
            if (flush_i) begin
                s2_valid <= 1'b0;
            end else if (adv_i) begin
                s2_valid <= s1_valid;
            end
            if (adv_i && s1_valid) begin
                s2_sign    <= s1_sign;
                s2_shifted <= s1_mag << lz;
                s2_exp     <= EXP_I2F_TOP - {3'b000, lz};
                s2_zero    <= mag_zero;
                s2_rmode   <= s1_rmode;
            end
        end
    end

    // Round the 24-bit significand; a fraction carry bumps the exponent (max 159, never inf)
    always_comb begin
        frac   = s2_shifted[30:8];
        lsb    = s2_shifted[8];
        guard  = s2_shifted[7];
        sticky = |s2_shifted[6:0];
        round_up = 1'b0;
        case (s2_rmode)
            RM_RNE:  round_up = guard & (sticky | lsb);
            RM_RTZ:  round_up = 1'b0;
            RM_RUP:  round_up = (guard | sticky) & ~s2_sign;
            RM_RDN:  round_up = (guard | sticky) & s2_sign;
            default: round_up = 1'b0;
        endcase
        {rnd_carry, frac_rnd} = {1'b0, frac} + {23'd0, round_up};
        exp_rnd    = s2_exp + {7'd0, rnd_carry};
        result_rnd = s2_zero ? 32'd0 : {s2_sign, exp_rnd, frac_rnd};
    end

    // Output stage; data only moves when a valid conversion arrives so outputs hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid   <= 1'b0;
            s3_result  <= 32'd0;
            s3_inexact <= 1'b0;
            s3_zero    <= 1'b0;
        end else begin
            if (flush_i) begin
                s3_valid <= 1'b0;
            end else if (adv_i) begin
                s3_valid <= s2_valid;
            end
            if (adv_i && s2_valid) begin
                s3_result  <= result_rnd;
                s3_inexact <= guard | sticky;
                s3_zero    <= s2_zero;
            end
        end
    end

    assign i2f_rdy_o     = s3_valid;
    assign i2f_result_o  = s3_result;
    assign i2f_inexact_o = s3_inexact;
    assign i2f_zero_o    = s3_zero;

endmodule

// File: tb/tb_pfpu32_i2f_conv.sv
// tb/tb_pfpu32_i2f_conv.sv - scoreboard bench for the int32 to float converter
module tb_pfpu32_i2f_conv;

    typedef struct packed {
        logic [31:0] result;
        logic        inexact;
        logic        zero;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        adv_i;
    logic        start_i;
    logic [31:0] opa_i;
    logic [1:0]  rmode_i;
    logic        i2f_rdy_o;
    logic [31:0] i2f_result_o;
    logic        i2f_inexact_o;
    logic        i2f_zero_o;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    logic fresh_q;

    pfpu32_i2f_conv dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .adv_i         (adv_i),
        .start_i       (start_i),
        .opa_i         (opa_i),
        .rmode_i       (rmode_i),
        .i2f_rdy_o     (i2f_rdy_o),
        .i2f_result_o  (i2f_result_o),
        .i2f_inexact_o (i2f_inexact_o),
        .i2f_zero_o    (i2f_zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // A result is new only when the last edge actually advanced the pipe
    always @(posedge clk) fresh_q <= adv_i & ~flush_i & ~rst;

    // Monitor: pop and compare every freshly presented result
    always @(negedge clk) begin
        if (!rst && i2f_rdy_o && fresh_q) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", {i2f_result_o, i2f_inexact_o, i2f_zero_o}, 34'd0);
                if ({i2f_result_o, i2f_inexact_o, i2f_zero_o} == 34'd0) begin
                    bad++;
                    $display("FAIL unexpected_result actual=rdy required=no_rdy");
                end
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", {i2f_result_o, i2f_inexact_o, i2f_zero_o},
                    {e.result, e.inexact, e.zero});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] opa, input logic [1:0] rm,
                         input logic [31:0] res, input logic inex, input logic zr);
        exp_t e;
        e.result  = res;
        e.inexact = inex;
        e.zero    = zr;
        sb.push_back(e);
        start_i = 1'b1;
        opa_i   = opa;
        rmode_i = rm;
        step();
        start_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            step();
            n++;
        end
        chk("drain_empty", 34'(sb.size()), 34'd0);
    endtask

    logic [33:0] held;

    initial begin
        rst = 1'b1; flush_i = 1'b0; adv_i = 1'b1; start_i = 1'b0;
        opa_i = 32'd0; rmode_i = 2'b00;
        step(); step();
        chk("reset_state", {i2f_rdy_o, i2f_result_o, i2f_inexact_o}, 34'd0);
        chk("reset_zero", {33'd0, i2f_zero_o}, 34'd0);
        rst = 1'b0;
        step();
        chk("idle_rdy", {33'd0, i2f_rdy_o}, 34'd0);

        // Back-to-back directed vectors
        issue(32'h00000001, 2'b00, 32'h3F800000, 1'b0, 1'b0);
        issue(32'hFFFFFFFF, 2'b00, 32'hBF800000, 1'b0, 1'b0);
        issue(32'h7FFFFFFF, 2'b00, 32'h4F000000, 1'b1, 1'b0);
        issue(32'h7FFFFFFF, 2'b01, 32'h4EFFFFFF, 1'b1, 1'b0);
        issue(32'h80000000, 2'b00, 32'hCF000000, 1'b0, 1'b0);
        issue(32'h00000000, 2'b00, 32'h00000000, 1'b0, 1'b1);
        issue(32'h00000000, 2'b10, 32'h00000000, 1'b0, 1'b1);
        issue(32'h00000000, 2'b11, 32'h00000000, 1'b0, 1'b1);
        issue(32'h01000001, 2'b00, 32'h4B800000, 1'b1, 1'b0);
        issue(32'h01000001, 2'b10, 32'h4B800001, 1'b1, 1'b0);
        issue(32'h01000001, 2'b11, 32'h4B800000, 1'b1, 1'b0);
        issue(32'hFEFFFFFF, 2'b11, 32'hCB800001, 1'b1, 1'b0);
        issue(32'hFEFFFFFF, 2'b10, 32'hCB800000, 1'b1, 1'b0);
        issue(32'hFEFFFFFF, 2'b01, 32'hCB800000, 1'b1, 1'b0);
        issue(32'h01000003, 2'b00, 32'h4B800002, 1'b1, 1'b0);
        issue(32'h00FFFFFF, 2'b00, 32'h4B7FFFFF, 1'b0, 1'b0);
        issue(32'h00000002, 2'b01, 32'h40000000, 1'b0, 1'b0);
        issue(32'hFFFFFFFE, 2'b10, 32'hC0000000, 1'b0, 1'b0);
        issue(32'h80000001, 2'b11, 32'hCF000000, 1'b1, 1'b0);
        drain();
        step(); step(); step();

        // Stall then flush with three operations in flight
        issue(32'h00000003, 2'b00, 32'h40400000, 1'b0, 1'b0);
        issue(32'h00000005, 2'b00, 32'h40A00000, 1'b0, 1'b0);
        issue(32'h00000007, 2'b00, 32'h40E00000, 1'b0, 1'b0);
        adv_i = 1'b0;
        held = {i2f_result_o, i2f_inexact_o, i2f_zero_o};
        chk("stall_entry", held, {32'h40400000, 2'b00});
        step();
        chk("stall_hold1", {i2f_result_o, i2f_inexact_o, i2f_zero_o}, {32'h40400000, 2'b00});
        chk("stall_rdy1", {33'd0, i2f_rdy_o}, 34'd1);
        step();
        chk("stall_hold2", {i2f_result_o, i2f_inexact_o, i2f_zero_o}, {32'h40400000, 2'b00});
        flush_i = 1'b1;
        sb.delete();
        step();
        flush_i = 1'b0;
        chk("flush_rdy", {33'd0, i2f_rdy_o}, 34'd0);
        adv_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_flush_rdy", {33'd0, i2f_rdy_o}, 34'd0);
        end

        // Pipe still usable after flush
        issue(32'hFFFFFFF6, 2'b00, 32'hC1200000, 1'b0, 1'b0);
        drain();

        // Reset mid-operation discards in-flight work and clears outputs
        issue(32'h00000009, 2'b00, 32'h41100000, 1'b0, 1'b0);
        issue(32'h0000000B, 2'b00, 32'h41300000, 1'b0, 1'b0);
        rst = 1'b1;
        sb.delete();
        step();
        rst = 1'b0;
        chk("midop_reset", {i2f_rdy_o, i2f_result_o, i2f_inexact_o}, 34'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_reset_rdy", {33'd0, i2f_rdy_o}, 34'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
